// File: rtl/sirv_tl_fragmenter_8.sv
// Splits logical TileLink A requests into single-byte fragments and rebuilds the D response stream.
// A and D paths are zero-latency combinational; one logical transaction is outstanding at a time.
module sirv_tl_fragmenter_8 #(
   parameter int MAX_SIZE = 3
) (
   input  logic        clock,
   input  logic        reset,
   output logic        io_repeat,
   output logic        io_in_a_ready,
   input  logic        io_in_a_valid,
   input  logic [2:0]  io_in_a_bits_opcode,
   input  logic [2:0]  io_in_a_bits_param,
   input  logic [2:0]  io_in_a_bits_size,
   input  logic [1:0]  io_in_a_bits_source,
   input  logic [29:0] io_in_a_bits_address,
   input  logic        io_in_a_bits_mask,
   input  logic [7:0]  io_in_a_bits_data,
   input  logic        io_out_a_ready,
   output logic        io_out_a_valid,
   output logic [2:0]  io_out_a_bits_opcode,
   output logic [2:0]  io_out_a_bits_param,
   output logic [2:0]  io_out_a_bits_size,
   output logic [1:0]  io_out_a_bits_source,
   output logic [29:0] io_out_a_bits_address,
   output logic        io_out_a_bits_mask,
   output logic [7:0]  io_out_a_bits_data,
   output logic        io_out_d_ready,
   input  logic        io_out_d_valid,
   input  logic [2:0]  io_out_d_bits_opcode,
   input  logic        io_out_d_bits_error,
   input  logic [7:0]  io_out_d_bits_data,
   input  logic        io_in_d_ready,
   output logic        io_in_d_valid,
   output logic [2:0]  io_in_d_bits_opcode,
   output logic [2:0]  io_in_d_bits_size,
   output logic [1:0]  io_in_d_bits_source,
   output logic        io_in_d_bits_error,
   output logic [7:0]  io_in_d_bits_data
);

   typedef enum logic [1:0] {IDLE, A_BUSY, WAIT_D} state_t;

   state_t                state_q, state_d;
   logic [MAX_SIZE-1:0]   a_idx_q, a_idx_d;
   logic [MAX_SIZE-1:0]   d_idx_q, d_idx_d;
   logic                  is_get_q, is_get_d;
   logic [2:0]            es_q, es_d;
   logic [1:0]            source_q, source_d;
   logic                  err_acc_q, err_acc_d;

   logic                  idle, not_wait;
   logic                  live_is_get, cur_is_get;
   logic [2:0]            live_es, cur_es;
   logic [1:0]            cur_source;
   logic [MAX_SIZE-1:0]   last_idx;
   logic                  err_base;
   logic                  a_fire, d_fire, d_last, d_fwd;
   logic                  a_done, d_done;
   logic                  unused_d_opcode;

   assign unused_d_opcode = &{1'b0, io_out_d_bits_opcode};

   assign idle        = (state_q == IDLE);
   assign not_wait    = (state_q != WAIT_D);
   assign live_is_get = ~((io_in_a_bits_opcode == 3'd0) | (io_in_a_bits_opcode == 3'd1));
   assign live_es     = (io_in_a_bits_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : io_in_a_bits_size;

   // In IDLE the transaction has not been latched yet, so the live request stands in for it.
   assign cur_is_get  = idle ? live_is_get : is_get_q;
   assign cur_es      = idle ? live_es : es_q;
   assign cur_source  = idle ? io_in_a_bits_source : source_q;
   assign err_base    = idle ? 1'b0 : err_acc_q;
   assign last_idx    = MAX_SIZE'((32'd1 << cur_es) - 32'd1);

   // A channel
   assign io_out_a_valid        = ~reset & io_in_a_valid & not_wait;
   assign io_in_a_ready         = ~reset & io_out_a_ready & not_wait;
   assign io_repeat             = ~reset & cur_is_get & (a_idx_q != last_idx) & not_wait;
   assign io_out_a_bits_opcode  = io_in_a_bits_opcode;
   assign io_out_a_bits_param   = io_in_a_bits_param;
   assign io_out_a_bits_size    = 3'd0;
   assign io_out_a_bits_source  = io_in_a_bits_source;
   assign io_out_a_bits_mask    = io_in_a_bits_mask;
   assign io_out_a_bits_data    = io_in_a_bits_data;
   assign io_out_a_bits_address = {io_in_a_bits_address[29:MAX_SIZE],
                                   io_in_a_bits_address[MAX_SIZE-1:0] | (a_idx_q & last_idx)};
   assign a_fire                = io_out_a_valid & io_out_a_ready;

   // D channel: Gets forward every beat, Puts forward only the last ack
   assign d_last              = (d_idx_q == last_idx);
   assign d_fwd               = cur_is_get | d_last;
   assign io_in_d_valid       = ~reset & io_out_d_valid & d_fwd;
   assign io_out_d_ready      = ~reset & (d_fwd ? io_in_d_ready : 1'b1);
   assign io_in_d_bits_opcode = cur_is_get ? 3'd1 : 3'd0;
   assign io_in_d_bits_size   = cur_es;
   assign io_in_d_bits_source = cur_source;
   assign io_in_d_bits_error  = cur_is_get ? io_out_d_bits_error : (err_base | io_out_d_bits_error);
   assign io_in_d_bits_data   = io_out_d_bits_data;
   assign d_fire              = io_out_d_valid & io_out_d_ready;

   always_comb begin
      state_d   = state_q;
      a_idx_d   = a_idx_q;
      d_idx_d   = d_idx_q;
      is_get_d  = is_get_q;
      es_d      = es_q;
      source_d  = source_q;
      err_acc_d = err_base;
      a_done    = 1'b0;
      d_done    = 1'b0;

      if (a_fire) begin
         if (idle) begin
            is_get_d = live_is_get;
            es_d     = live_es;
            source_d = io_in_a_bits_source;
         end
         if (a_idx_q == last_idx) begin
            a_idx_d = '0;
            a_done  = 1'b1;
         end else begin
            a_idx_d = a_idx_q + MAX_SIZE'(1);
         end
      end

      if (d_fire) begin
         if (d_last) begin
            d_idx_d = '0;
            d_done  = 1'b1;
         end else begin
            d_idx_d = d_idx_q + MAX_SIZE'(1);
            if (!cur_is_get) err_acc_d = err_base | io_out_d_bits_error;
         end
      end

      // Final D wins even if the last A fragment fires in the same cycle.
      if (d_done)       state_d = IDLE;
      else if (a_done)  state_d = WAIT_D;
      else if (a_fire)  state_d = A_BUSY;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         a_idx_q   <= '0;
         d_idx_q   <= '0;
         is_get_q  <= 1'b0;
         es_q      <= 3'd0;
         source_q  <= 2'd0;
         err_acc_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_idx_q   <= a_idx_d;
         d_idx_q   <= d_idx_d;
         is_get_q  <= is_get_d;
         es_q      <= es_d;
         source_q  <= source_d;
         err_acc_q <= err_acc_d;
      end
   end

endmodule

// File: tb/tb_sirv_tl_fragmenter_8.sv
// Randomized bench for sirv_tl_fragmenter_8: a transaction-level model predicts fragments and responses.
module tb_sirv_tl_fragmenter_8;
   localparam int MAX_SIZE = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_repeat, io_in_a_ready, io_in_a_valid;
   logic [2:0]  io_in_a_bits_opcode, io_in_a_bits_param, io_in_a_bits_size;
   logic [1:0]  io_in_a_bits_source;
   logic [29:0] io_in_a_bits_address;
   logic        io_in_a_bits_mask;
   logic [7:0]  io_in_a_bits_data;
   logic        io_out_a_ready, io_out_a_valid;
   logic [2:0]  io_out_a_bits_opcode, io_out_a_bits_param, io_out_a_bits_size;
   logic [1:0]  io_out_a_bits_source;
   logic [29:0] io_out_a_bits_address;
   logic        io_out_a_bits_mask;
   logic [7:0]  io_out_a_bits_data;
   logic        io_out_d_ready, io_out_d_valid;
   logic [2:0]  io_out_d_bits_opcode;
   logic        io_out_d_bits_error;
   logic [7:0]  io_out_d_bits_data;
   logic        io_in_d_ready, io_in_d_valid;
   logic [2:0]  io_in_d_bits_opcode, io_in_d_bits_size;
   logic [1:0]  io_in_d_bits_source;
   logic        io_in_d_bits_error;
   logic [7:0]  io_in_d_bits_data;

   always #5 clock = ~clock;

   sirv_tl_fragmenter_8 #(.MAX_SIZE(MAX_SIZE)) dut (
      .clock(clock), .reset(reset), .io_repeat(io_repeat),
      .io_in_a_ready(io_in_a_ready), .io_in_a_valid(io_in_a_valid),
      .io_in_a_bits_opcode(io_in_a_bits_opcode), .io_in_a_bits_param(io_in_a_bits_param),
      .io_in_a_bits_size(io_in_a_bits_size), .io_in_a_bits_source(io_in_a_bits_source),
      .io_in_a_bits_address(io_in_a_bits_address), .io_in_a_bits_mask(io_in_a_bits_mask),
      .io_in_a_bits_data(io_in_a_bits_data),
      .io_out_a_ready(io_out_a_ready), .io_out_a_valid(io_out_a_valid),
      .io_out_a_bits_opcode(io_out_a_bits_opcode), .io_out_a_bits_param(io_out_a_bits_param),
      .io_out_a_bits_size(io_out_a_bits_size), .io_out_a_bits_source(io_out_a_bits_source),
      .io_out_a_bits_address(io_out_a_bits_address), .io_out_a_bits_mask(io_out_a_bits_mask),
      .io_out_a_bits_data(io_out_a_bits_data),
      .io_out_d_ready(io_out_d_ready), .io_out_d_valid(io_out_d_valid),
      .io_out_d_bits_opcode(io_out_d_bits_opcode), .io_out_d_bits_error(io_out_d_bits_error),
      .io_out_d_bits_data(io_out_d_bits_data),
      .io_in_d_ready(io_in_d_ready), .io_in_d_valid(io_in_d_valid),
      .io_in_d_bits_opcode(io_in_d_bits_opcode), .io_in_d_bits_size(io_in_d_bits_size),
      .io_in_d_bits_source(io_in_d_bits_source), .io_in_d_bits_error(io_in_d_bits_error),
      .io_in_d_bits_data(io_in_d_bits_data)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Downstream memory contents seen by Get fragments
   function automatic logic [7:0] rd(input logic [29:0] a);
      return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5C;
   endfunction

   function automatic bit chance(input int pct);
      return int'($urandom_range(0, 99)) < pct;
   endfunction

   task automatic idle_inputs();
      io_in_a_valid = 1'b0;
      io_out_d_valid = 1'b0;
      io_out_d_bits_error = 1'b0;
   endtask

   // Runs one logical transaction; entered and left at 1 time unit after a rising edge.
   task automatic run_txn(input logic [2:0] op, input logic [2:0] sz, input logic [29:0] addr,
                          input logic [1:0] src, input logic [2:0] prm, input logic msk,
                          input logic [7:0] dat0, input logic [7:0] err_mask,
                          input int pa, input int pv, input int pr, output int cycles);
      int          n;
      bit          get, afire, dfire, fwd, dv_hold;
      logic [29:0] base;
      logic [7:0]  lane_mask;
      int          a_cnt, d_cnt, up_cnt, up_exp, k;
      int          q[$];
      assert (sz <= 3'(MAX_SIZE)) else begin
         n_fail++;
         $error("FAIL size_legal: observed %0d allowed %0d", sz, MAX_SIZE);
      end
      n         = 1 << sz;
      get       = !(op == 3'd0 || op == 3'd1);
      base      = addr & ~30'(n - 1);
      lane_mask = 8'((1 << n) - 1);
      a_cnt = 0; d_cnt = 0; up_cnt = 0; k = 0;
      up_exp  = get ? n : 1;
      dv_hold = 1'b0;
      cycles  = 0;
      while ((a_cnt < n || d_cnt < n) && cycles < 500) begin
         io_in_a_valid = 1'b1;
         if (a_cnt < n) begin
            io_in_a_bits_opcode  = op;
            io_in_a_bits_param   = prm;
            io_in_a_bits_size    = sz;
            io_in_a_bits_source  = src;
            io_in_a_bits_address = base;
            io_in_a_bits_mask    = msk;
            io_in_a_bits_data    = get ? dat0 : dat0 + 8'(a_cnt);
         end else begin
            // a competing request that must stay blocked
            io_in_a_bits_opcode  = 3'($urandom);
            io_in_a_bits_param   = 3'($urandom);
            io_in_a_bits_size    = 3'($urandom_range(0, 3));
            io_in_a_bits_source  = 2'($urandom);
            io_in_a_bits_address = 30'($urandom) & ~30'h7;
            io_in_a_bits_mask    = 1'($urandom);
            io_in_a_bits_data    = 8'($urandom);
         end
         io_out_a_ready = chance(pa);
         io_in_d_ready  = chance(pr);
         afire = (a_cnt < n) && io_out_a_ready;
         if (afire) q.push_back(a_cnt);
         if (!dv_hold) dv_hold = (q.size() > 0) && chance(pv);
         io_out_d_valid = dv_hold;
         if (dv_hold) begin
            k = q[0];
            io_out_d_bits_opcode = get ? 3'd1 : 3'd0;
            io_out_d_bits_data   = get ? rd(base | 30'(k)) : 8'($urandom);
            io_out_d_bits_error  = err_mask[k];
         end else begin
            io_out_d_bits_opcode = 3'd0;
            io_out_d_bits_data   = 8'($urandom);
            io_out_d_bits_error  = 1'($urandom);
         end
         @(negedge clock);
         fwd = get || (d_cnt == n - 1);
         check("out_a_valid", 32'(io_out_a_valid), 32'(a_cnt < n));
         check("in_a_ready", 32'(io_in_a_ready), 32'((a_cnt < n) && io_out_a_ready));
         check("repeat", 32'(io_repeat), 32'((a_cnt < n) && get && (a_cnt != n - 1)));
         if (afire) begin
            check("frag_addr", 32'(io_out_a_bits_address), 32'(base | 30'(a_cnt)));
            check("frag_size", 32'(io_out_a_bits_size), 32'd0);
            check("frag_data", 32'(io_out_a_bits_data), 32'(get ? dat0 : dat0 + 8'(a_cnt)));
            check("frag_fields", 32'({io_out_a_bits_opcode, io_out_a_bits_param,
                                      io_out_a_bits_source, io_out_a_bits_mask}),
                  32'({op, prm, src, msk}));
         end
         check("in_d_valid", 32'(io_in_d_valid), 32'(dv_hold && fwd));
         check("out_d_ready", 32'(io_out_d_ready), 32'(fwd ? io_in_d_ready : 1'b1));
         dfire = dv_hold && (fwd ? io_in_d_ready : 1'b1);
         if (dv_hold && fwd && io_in_d_ready) begin
            check("up_opcode", 32'(io_in_d_bits_opcode), get ? 32'd1 : 32'd0);
            check("up_size", 32'(io_in_d_bits_size), 32'(sz));
            check("up_source", 32'(io_in_d_bits_source), 32'(src));
            check("up_error", 32'(io_in_d_bits_error),
                  32'(get ? err_mask[k] : |(err_mask & lane_mask)));
            if (get) check("up_data", 32'(io_in_d_bits_data), 32'(rd(base | 30'(k))));
            up_cnt++;
         end
         @(posedge clock);
         #1;
         cycles++;
         if (afire) a_cnt++;
         if (dfire) begin
            void'(q.pop_front());
            d_cnt++;
            dv_hold = 1'b0;
         end
      end
      check("txn_complete", 32'(a_cnt == n && d_cnt == n && up_cnt == up_exp), 32'd1);
      idle_inputs();
   endtask

   initial begin
      int cyc;
      logic [7:0] op_r;
      // reset with every handshake input asserted: all outputs must stay quiet
      reset = 1'b1;
      io_in_a_valid = 1'b1; io_in_a_bits_opcode = 3'd4; io_in_a_bits_param = 3'd0;
      io_in_a_bits_size = 3'd3; io_in_a_bits_source = 2'd1; io_in_a_bits_address = 30'h100;
      io_in_a_bits_mask = 1'b1; io_in_a_bits_data = 8'h00;
      io_out_a_ready = 1'b1; io_out_d_valid = 1'b1; io_out_d_bits_opcode = 3'd1;
      io_out_d_bits_error = 1'b0; io_out_d_bits_data = 8'h00; io_in_d_ready = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_repeat", 32'(io_repeat), 32'd0);
      check("rst_in_a_ready", 32'(io_in_a_ready), 32'd0);
      check("rst_out_a_valid", 32'(io_out_a_valid), 32'd0);
      check("rst_in_d_valid", 32'(io_in_d_valid), 32'd0);
      check("rst_out_d_ready", 32'(io_out_d_ready), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle_inputs();
      @(posedge clock);
      #1;

      // Get size 2 at full speed
      run_txn(3'd4, 3'd2, 30'h100, 2'd2, 3'd0, 1'b1, 8'h00, 8'h00, 100, 100, 100, cyc);
      // PutFull size 3 with data 0x10..0x17
      run_txn(3'd0, 3'd3, 30'h240, 2'd1, 3'd0, 1'b1, 8'h10, 8'h00, 100, 70, 100, cyc);
      // PutPartial size 1: first ack errors, then clean
      run_txn(3'd1, 3'd1, 30'h3A, 2'd3, 3'd0, 1'b0, 8'hC0, 8'h01, 100, 100, 100, cyc);
      run_txn(3'd1, 3'd1, 30'h3A, 2'd3, 3'd0, 1'b0, 8'hC0, 8'h00, 100, 100, 100, cyc);
      // Get size 3 under random backpressure
      run_txn(3'd4, 3'd3, 30'h1238, 2'd0, 3'd0, 1'b1, 8'h00, 8'h24, 50, 60, 50, cyc);
      // size 0 Get answered in the same cycle, twice back to back
      run_txn(3'd4, 3'd0, 30'h77, 2'd1, 3'd0, 1'b1, 8'h00, 8'h00, 100, 100, 100, cyc);
      check("size0_cycles_a", 32'(cyc), 32'd1);
      run_txn(3'd4, 3'd0, 30'h78, 2'd2, 3'd0, 1'b1, 8'h00, 8'h01, 100, 100, 100, cyc);
      check("size0_cycles_b", 32'(cyc), 32'd1);

      // randomized mix of opcodes, sizes and backpressure
      for (int t = 0; t < 30; t++) begin
         op_r = 8'($urandom_range(0, 7));
         run_txn(op_r[2:0], 3'($urandom_range(0, 3)), 30'($urandom), 2'($urandom),
                 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom_range(0, 255)),
                 int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
                 int'($urandom_range(30, 100)), cyc);
      end

      // reset while in A_BUSY with two fragments issued
      io_in_a_valid = 1'b1; io_in_a_bits_opcode = 3'd4; io_in_a_bits_size = 3'd3;
      io_in_a_bits_address = 30'h2000; io_in_a_bits_source = 2'd1;
      io_out_a_ready = 1'b1; io_in_d_ready = 1'b0; io_out_d_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      io_out_a_ready = 1'b0;
      @(negedge clock);
      check("busy_addr", 32'(io_out_a_bits_address), 32'h2002);
      check("busy_repeat", 32'(io_repeat), 32'd1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      io_out_a_ready = 1'b1; io_out_d_valid = 1'b1; io_in_d_ready = 1'b1;
      @(negedge clock);
      check("midrst_repeat", 32'(io_repeat), 32'd0);
      check("midrst_in_d_valid", 32'(io_in_d_valid), 32'd0);
      check("midrst_out_a_valid", 32'(io_out_a_valid), 32'd0);
      check("midrst_out_d_ready", 32'(io_out_d_ready), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      idle_inputs();
      run_txn(3'd4, 3'd3, 30'h2000, 2'd1, 3'd0, 1'b1, 8'h00, 8'h00, 100, 80, 100, cyc);
      run_txn(3'd0, 3'd2, 30'h2010, 2'd0, 3'd0, 1'b1, 8'hE0, 8'h08, 100, 100, 100, cyc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
